// File: rtl/servo_pwm_gen_pkg.sv
// Shared constants, widths and angle-to-pulse mapping for the servo PWM generator.
package servo_pwm_gen_pkg;

  localparam int unsigned ANGLE_W = 8;
  localparam int unsigned PULSE_W = 12;
  localparam int unsigned PROD_W  = 20;

  localparam int unsigned DEF_CLK_HZ    = 50000000;
  localparam int unsigned DEF_FRAME_US  = 20000;
  localparam int unsigned DEF_MIN_US    = 500;
  localparam int unsigned DEF_MAX_US    = 2500;
  localparam int unsigned DEF_MAX_ANGLE = 180;

  typedef logic [ANGLE_W-1:0] angle_t;
  typedef logic [PULSE_W-1:0] pulse_t;

  // Clock cycles per microsecond.
  function automatic int unsigned calc_div(input int unsigned clk_hz);
    return clk_hz / 1000000;
  endfunction

  // Microseconds per degree in 8.8 fixed point, truncated.
  function automatic int unsigned calc_scale(input int unsigned min_us, input int unsigned max_us,
                                             input int unsigned max_angle);
    return ((max_us - min_us) * 256) / max_angle;
  endfunction

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Clamp the angle, then map linearly onto the pulse width in microseconds.
  function automatic pulse_t angle_to_us(input angle_t angle, input int unsigned min_us,
                                         input int unsigned max_angle, input int unsigned scale);
    angle_t              a;
    logic [PROD_W-1:0]   prod;
    a    = (32'(angle) > max_angle) ? ANGLE_W'(max_angle) : angle;
    prod = PROD_W'(a) * PROD_W'(scale);
    return PULSE_W'(min_us + 32'(prod >> 8));
  endfunction

endpackage

// File: rtl/servo_us_tick.sv
// Prescaler dividing the system clock down to a one-microsecond tick.
module servo_us_tick
  import servo_pwm_gen_pkg::*;
#(
  parameter  int unsigned DIV   = 50,
  localparam int unsigned PRE_W = cnt_w(DIV)
) (
  input  logic             Clk,
  input  logic             Rst_n,
  output logic [PRE_W-1:0] pre_cnt,
  output logic             tick_c
);

  assign tick_c = (pre_cnt == PRE_W'(DIV - 1));

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n)      pre_cnt <= '0;
    else if (tick_c) pre_cnt <= '0;
    else             pre_cnt <= pre_cnt + PRE_W'(1);
  end

endmodule

// File: rtl/servo_pwm_gen.sv
// Hobby-servo PWM generator: frame counter, per-frame shadow of angle/enable, pulse compare.
module servo_pwm_gen
  import servo_pwm_gen_pkg::*;
#(
  parameter int unsigned CLK_HZ    = DEF_CLK_HZ,
  parameter int unsigned FRAME_US  = DEF_FRAME_US,
  parameter int unsigned MIN_US    = DEF_MIN_US,
  parameter int unsigned MAX_US    = DEF_MAX_US,
  parameter int unsigned MAX_ANGLE = DEF_MAX_ANGLE
) (
  input  logic               Clk,
  input  logic               Rst_n,
  input  logic [ANGLE_W-1:0] iAngle,
  input  logic               iEn,
  output logic               oPwm,
  output logic               oFrameStart,
  output logic [PULSE_W-1:0] oPulseUs,
  output logic               oClamped
);

  localparam int unsigned DIV   = calc_div(CLK_HZ);
  localparam int unsigned SCALE = calc_scale(MIN_US, MAX_US, MAX_ANGLE);
  localparam int unsigned PRE_W = cnt_w(DIV);
  localparam int unsigned US_W  = cnt_w(FRAME_US);

  logic [PRE_W-1:0] pre_cnt;
  logic             tick_c;
  logic [US_W-1:0]  us_cnt;
  logic [US_W-1:0]  us_cnt_nxt;
  logic             en_q;
  logic             en_nxt;
  logic             pwm_nxt;
  logic             fs_nxt;
  logic             clamp_nxt;
  pulse_t           pulse_nxt;
  logic             boundary_c;
  logic             fall_c;

  servo_us_tick #(.DIV(DIV)) u_tick (
    .Clk     (Clk),
    .Rst_n   (Rst_n),
    .pre_cnt (pre_cnt),
    .tick_c  (tick_c)
  );

  assign boundary_c = (pre_cnt == '0) && (us_cnt == '0);
  assign fall_c     = (pre_cnt == '0) && (32'(us_cnt) == 32'(oPulseUs));

  // Frame counter advance, boundary sampling and pulse shaping.
  always_comb begin
    us_cnt_nxt = us_cnt;
    en_nxt     = en_q;
    pulse_nxt  = oPulseUs;
    clamp_nxt  = oClamped;
    fs_nxt     = 1'b0;
    pwm_nxt    = oPwm & en_q;

    if (tick_c) begin
      us_cnt_nxt = (us_cnt == US_W'(FRAME_US - 1)) ? '0 : us_cnt + US_W'(1);
    end

    // The new frame's enable drives the output from its very first cycle.
    if (boundary_c) begin
      en_nxt    = iEn;
      pulse_nxt = angle_to_us(iAngle, MIN_US, MAX_ANGLE, SCALE);
      clamp_nxt = (32'(iAngle) > MAX_ANGLE);
      fs_nxt    = 1'b1;
      pwm_nxt   = iEn;
    end else if (fall_c) begin
      pwm_nxt   = 1'b0;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      us_cnt      <= '0;
      en_q        <= 1'b0;
      oPulseUs    <= '0;
      oClamped    <= 1'b0;
      oFrameStart <= 1'b0;
      oPwm        <= 1'b0;
    end else begin
      us_cnt      <= us_cnt_nxt;
      en_q        <= en_nxt;
      oPulseUs    <= pulse_nxt;
      oClamped    <= clamp_nxt;
      oFrameStart <= fs_nxt;
      oPwm        <= pwm_nxt;
    end
  end

endmodule

// File: tb/tb_servo_pwm_gen.sv
// Self-checking bench for servo_pwm_gen: frame-position reference model plus directed scenarios.
`timescale 1ns/1ps
module tb_servo_pwm_gen;
  import servo_pwm_gen_pkg::*;

  localparam int CLK_HZ     = 4000000;
  localparam int FRAME_US   = 3000;
  localparam int MIN_US     = 500;
  localparam int MAX_US     = 2500;
  localparam int MAX_ANGLE  = 180;
  localparam int DIV        = CLK_HZ / 1000000;
  localparam int SCALE      = ((MAX_US - MIN_US) * 256) / MAX_ANGLE;
  localparam int FRAME_CLKS = FRAME_US * DIV;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic [7:0]  angle = 8'd60;
  logic        en    = 1'b1;
  logic        pwm;
  logic        fs;
  logic [11:0] pulse_us;
  logic        clamped;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  servo_pwm_gen #(
    .CLK_HZ    (CLK_HZ),
    .FRAME_US  (FRAME_US),
    .MIN_US    (MIN_US),
    .MAX_US    (MAX_US),
    .MAX_ANGLE (MAX_ANGLE)
  ) dut (
    .Clk         (clk),
    .Rst_n       (rst_n),
    .iAngle      (angle),
    .iEn         (en),
    .oPwm        (pwm),
    .oFrameStart (fs),
    .oPulseUs    (pulse_us),
    .oClamped    (clamped)
  );

  // Reference model state: position of the current cycle within its frame.
  int cyc = 0;
  int pos = 0;
  int m_pulse = 0;
  bit m_en = 1'b0;
  bit m_clamp = 1'b0;
  bit m_fs = 1'b0;
  bit m_pwm = 1'b0;

  function automatic int ref_us(input int a);
    int c;
    c = (a > MAX_ANGLE) ? MAX_ANGLE : a;
    return MIN_US + (c * SCALE) / 256;
  endfunction

  task automatic check(input string tag, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0d expected=%0d", tag, cyc, act, exp);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc = 0; pos = 0; m_pulse = 0; m_en = 0; m_clamp = 0; m_fs = 0; m_pwm = 0;
    end else begin
      cyc++;
      m_fs = (pos == 0);
      if (pos == 0) begin
        m_pulse = ref_us(int'(angle));
        m_clamp = (int'(angle) > MAX_ANGLE);
        m_en    = en;
      end
      pos   = (pos + 1) % FRAME_CLKS;
      m_pwm = m_en && (pos >= 1) && (pos <= m_pulse * DIV);
    end
  end

  // Per-cycle comparison against the model, plus pulse-width and frame-start logs.
  int run = 0;
  int wq[$];
  int fq[$];

  always @(negedge clk) begin
    if (rst_n) begin
      check("pwm", int'(pwm), int'(m_pwm));
      check("frame_start", int'(fs), int'(m_fs));
      check("pulse_us", int'(pulse_us), m_pulse);
      check("clamped", int'(clamped), int'(m_clamp));
      if (pwm) run++;
      else if (run > 0) begin wq.push_back(run); run = 0; end
      if (fs) fq.push_back(cyc);
    end else begin
      run = 0;
    end
  end

  function automatic int qat(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic goto(input int target);
    int guard;
    guard = 0;
    while (cyc < target && guard < 20000) begin
      step();
      guard++;
    end
    check("goto_reached", cyc, target);
  endtask

  // Random junk on the inputs mid-frame, then restore the intended values.
  task automatic wiggle(input int n, input logic [7:0] a_keep, input logic e_keep);
    repeat (n) begin
      angle = 8'($urandom);
      en    = 1'($urandom);
      step();
    end
    angle = a_keep;
    en    = e_keep;
  endtask

  task automatic pulse_reset(input int hold);
    rst_n = 1'b0;
    #1;
    check("async_pwm_low", int'(pwm), 0);
    check("rst_frame_start", int'(fs), 0);
    check("rst_pulse_us", int'(pulse_us), 0);
    check("rst_clamped", int'(clamped), 0);
    repeat (hold) step();
    rst_n = 1'b1;
    fq.delete();
    wq.delete();
  endtask

  initial begin
    int r;
    #400_000_000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int r;
    for (int a = 0; a < 256; a++)
      check("angle_to_us", int'(angle_to_us(8'(a), MIN_US, MAX_ANGLE, SCALE)), ref_us(a));

    #2 rst_n = 1'b0;
    repeat (3) step();
    check("reset_pwm", int'(pwm), 0);
    check("reset_fs", int'(fs), 0);
    check("reset_pulse", int'(pulse_us), 0);
    check("reset_clamped", int'(clamped), 0);
    angle = 8'd60; en = 1'b1;
    rst_n = 1'b1;

    // Frames 1-4: 60 (changed to 180 mid-pulse), 180 (iEn dropped), disabled, 0.
    goto(1);
    check("first_fs", int'(fs), 1);
    check("first_pulse", int'(pulse_us), 1166);
    check("first_pwm", int'(pwm), 1);
    goto(2000);
    check("mid_pulse_pwm", int'(pwm), 1);
    angle = 8'd180;
    goto(12400);
    en = 1'b0; angle = 8'd0;
    goto(24400);
    wiggle(3000, 8'd0, 1'b1);
    goto(38400);
    check("fs_count", fq.size(), 4);
    check("fs_first_cycle", qat(fq, 0), 1);
    check("frame_period", qat(fq, 1) - qat(fq, 0), 12000);
    check("fs_disabled_frame", qat(fq, 2), 24001);
    check("fs_after_enable", qat(fq, 3), 36001);
    check("width_count", wq.size(), 3);
    check("width_60", qat(wq, 0), 4664);
    check("width_180_en_drop", qat(wq, 1), 9996);
    check("width_0", qat(wq, 2), 2000);

    angle = 8'd90;
    pulse_reset(3);
    goto(1);
    check("pulse_90", int'(pulse_us), 1499);
    check("clamped_90", int'(clamped), 0);
    goto(100);
    wiggle(4000, 8'd90, 1'b1);
    goto(6400);
    check("width_90", qat(wq, 0), 5996);

    angle = 8'd200;
    pulse_reset(3);
    goto(1);
    check("pulse_200", int'(pulse_us), 2499);
    check("clamped_200", int'(clamped), 1);
    goto(10000);
    check("clamped_200_late", int'(clamped), 1);
    goto(10400);
    check("width_200", qat(wq, 0), 9996);

    angle = 8'd255;
    pulse_reset(3);
    goto(1);
    check("pulse_255", int'(pulse_us), 2499);
    check("clamped_255", int'(clamped), 1);
    goto(10400);

    angle = 8'd100;
    pulse_reset(3);
    goto(1);
    check("pulse_100", int'(pulse_us), 1610);
    check("clamped_100", int'(clamped), 0);
    goto(800);
    check("pwm_before_reset", int'(pwm), 1);
    r = int'($urandom_range(0, 255));
    angle = 8'(r);
    pulse_reset(3);

    goto(1);
    check("post_reset_fs", int'(fs), 1);
    check("post_reset_pwm", int'(pwm), 1);
    check("post_reset_pulse", int'(pulse_us), ref_us(r));
    check("post_reset_clamped", int'(clamped), (r > MAX_ANGLE) ? 1 : 0);
    goto(ref_us(r) * DIV + 10);
    check("post_reset_width", qat(wq, 0), ref_us(r) * DIV);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/servo_pwm_gen.md
Name: servo_pwm_gen

Overview:
- Downstream stage of the servo angle UI block.
- Consumes the 8-bit angle (0..180 degrees) and produces a standard hobby-servo PWM: a fixed frame with a high pulse of MIN_US..MAX_US microseconds, linear in angle.
- The angle is sampled only at frame boundaries, so changes on iAngle never produce a runt or stretched pulse.
- Sits between the angle UI and the servo output pin.

Parameters:
- CLK_HZ, 50000000, system clock frequency; must be an integer multiple of 1 MHz.
- FRAME_US, 20000, frame period in microseconds.
- MIN_US, 500, pulse width at angle 0.
- MAX_US, 2500, pulse width at angle MAX_ANGLE; requires MAX_US < FRAME_US.
- MAX_ANGLE, 180, largest legal angle; larger inputs are clamped.

Ports:
- Clk  in  1  system clock.
- Rst_n  in  1  reset; asynchronous assert, active low.
- iAngle  in  8  requested angle in degrees, from the UI stage.
- iEn  in  1  output enable, sampled at frame boundary.
- oPwm  out  1  servo PWM output, registered.
- oFrameStart  out  1  one-cycle strobe, high in the first cycle of each frame.
- oPulseUs  out  12  pulse width latched for the current frame, in microseconds.
- oClamped  out  1  high for the whole frame when that frame's sampled iAngle exceeded MAX_ANGLE.

Behaviour:
- Reset is Rst_n, asynchronous, active-low; the clock is Clk.
- Derived constants:
  - DIV = CLK_HZ/1000000.
  - SCALE = ((MAX_US-MIN_US)*256)/MAX_ANGLE, integer-truncated at elaboration. The default is 2844.
- Reset values:
  - Counters: pre_cnt=0, us_cnt=0.
  - Outputs: oPwm=0, oFrameStart=0, oPulseUs=0, oClamped=0.
  - Shadow enable: 0.
- Prescaler pre_cnt runs 0..DIV-1 and wraps. us_cnt increments when pre_cnt==DIV-1 and wraps FRAME_US-1 -> 0.
- Boundary cycle B is any cycle with pre_cnt==0 and us_cnt==0. This includes the first active cycle after reset release.
- On the edge ending B:
  - a = min(iAngle, MAX_ANGLE).
  - oPulseUs <= MIN_US + ((a*SCALE)>>8), using a 20-bit intermediate product with truncating shift.
  - oClamped <= (iAngle > MAX_ANGLE).
  - Shadow enable <= iEn.
  - oFrameStart <= 1; it is cleared on the following edge.
- oPwm is registered from next-state values, so the new frame's shadow applies from the frame's first cycle:
  - It rises on the edge ending B when the new shadow enable is 1.
  - It falls on the edge ending the cycle where pre_cnt==0 and us_cnt==oPulseUs.
  - High time is exactly oPulseUs*DIV clocks. Frame period is exactly FRAME_US*DIV clocks.
- Changes to iAngle or iEn mid-frame are ignored until the next B. A pulse that is in progress always completes.
- With shadow enable 0, oPwm stays 0 for the whole frame. Counters keep running and oFrameStart still pulses.
- Reset asserted mid-pulse forces oPwm low immediately (asynchronous). After release, a new frame begins at the first active cycle.
- Reference widths:
  - angle 0 -> 500 us.
  - 60 -> 1166 us.
  - 90 -> 1499 us.
  - 180 -> 2499 us.
  - 255 -> 2499 us with oClamped=1.

Decomposition:
- Shared package holds:
  - DIV, SCALE, counter widths (clog2 of DIV and of FRAME_US), and the 12-bit pulse type.
  - A function angle_to_us(angle), used by both the RTL and the bench model.
- One natural sub-module, servo_us_tick: the prescaler producing pre_cnt and a one-cycle tick when pre_cnt==DIV-1.
- Frame counter, shadow registers and compare logic stay in servo_pwm_gen.

Test Plan:
- Bench parameters for all scenarios: CLK_HZ=4000000 (DIV=4), FRAME_US=3000.
- Reset release with iAngle=60, iEn=1:
  - oFrameStart high in cycle 1.
  - oPulseUs=1166.
  - oPwm high for exactly 4664 clocks.
  - Next oFrameStart 12000 clocks after the first.
- Sweep iAngle 0, 90, 180, each held for one frame:
  - Pulse widths 2000, 5996, 9996 clocks.
  - oClamped=0 throughout.
- iAngle=200, then 255:
  - oPulseUs=2499 both frames.
  - oClamped=1 for those frames.
  - oClamped returns to 0 when iAngle=100 is sampled.
- Change iAngle 60->180 at us_cnt=500, mid-pulse:
  - The current pulse still ends at 4664 clocks.
  - The next frame's pulse is 9996 clocks.
- Drop iEn at us_cnt=100:
  - The current pulse completes.
  - The next frame has oPwm=0 for all 12000 clocks while oFrameStart still pulses.
  - Re-enabling restores the pulse at the following boundary.
- Assert Rst_n low for 3 clocks at us_cnt=200:
  - oPwm drops to 0 asynchronously.
  - After release, oFrameStart and oPwm rise in the first active cycle with the current angle.
